// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: parallel load, logical shifts with serial in,
// rotates and clear, plus a saturating shift counter for SIPO/PISO framing.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_l,
  input  logic                         sin_r,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_msb,
  output logic                         sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0]   shift_count,
  output logic                         count_done
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_p0;
  logic [CW-1:0]    count_p0;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    count_nxt;

  // Count sticks at WIDTH so count_done stays asserted while extra shifts run.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == COUNT_MAX) ? c : c + CW'(1);
  endfunction

  always_comb begin
    q_nxt     = q_p0;
    count_nxt = count_p0;
    if (en) begin
      case (mode_t'(mode))
        MODE_LOAD: begin
          q_nxt     = d;
          count_nxt = '0;
        end
        MODE_SHL: begin
          q_nxt     = {q_p0[WIDTH-2:0], sin_l};
          count_nxt = sat_inc(count_p0);
        end
        MODE_SHR: begin
          q_nxt     = {sin_r, q_p0[WIDTH-1:1]};
          count_nxt = sat_inc(count_p0);
        end
        MODE_ROL: begin
          q_nxt     = {q_p0[WIDTH-2:0], q_p0[WIDTH-1]};
          count_nxt = sat_inc(count_p0);
        end
        MODE_ROR: begin
          q_nxt     = {q_p0[0], q_p0[WIDTH-1:1]};
          count_nxt = sat_inc(count_p0);
        end
        MODE_CLEAR: begin
          q_nxt     = RESET_VALUE;
          count_nxt = '0;
        end
        default: begin
          q_nxt     = q_p0;
          count_nxt = count_p0;
        end
      endcase
    end
  end

  // Stage p0: register bank and shift counter
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0     <= RESET_VALUE;
      count_p0 <= '0;
    end else begin
      q_p0     <= q_nxt;
      count_p0 <= count_nxt;
    end
  end

  assign q           = q_p0;
  assign sout_msb    = q_p0[WIDTH-1];
  assign sout_lsb    = q_p0[0];
  assign shift_count = count_p0;
  assign count_done  = (count_p0 == COUNT_MAX);

endmodule
